// File: rtl/fp_norm_pkg.sv
// Shared widths and FSM state encoding for the sequential mantissa normalizer.
package fp_norm_pkg;

  localparam int unsigned MANT_W  = 24;
  localparam int unsigned EXP_W   = 8;
  localparam int unsigned SHIFT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/norm_lz4.sv
// 4-bit leading-zero counter (0..4) used by the multi-bit scan step.
// Only built when NORM_SHIFT4_EN is defined.
`ifdef NORM_SHIFT4_EN
module norm_lz4 (
  input  logic [3:0] i_nib,
  output logic [2:0] o_lz
);

  always_comb begin
    o_lz = 3'd4;
    if (i_nib[3])      o_lz = 3'd0;
    else if (i_nib[2]) o_lz = 3'd1;
    else if (i_nib[1]) o_lz = 3'd2;
    else if (i_nib[0]) o_lz = 3'd3;
  end

endmodule
`endif

// File: rtl/fp_norm_seq.sv
// Sequential mantissa normalizer: shifts left until hidden bit set or exponent floor reached.
// NORM_SHIFT4_EN enables up to 4-bit steps per scan cycle (same results, lower latency).
module fp_norm_seq
  import fp_norm_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MANT_W-1:0]  in_mant,
  input  logic [EXP_W-1:0]   in_exp,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [MANT_W-1:0]  out_mant,
  output logic [EXP_W-1:0]   out_exp,
  output logic [SHIFT_W-1:0] out_shift,
  output logic               out_zero,
  output logic               out_subn
);

  state_t               r_state, w_state_nxt;
  logic [MANT_W-1:0]    r_mant;
  logic [EXP_W-1:0]     r_exp;
  logic [SHIFT_W-1:0]   r_shift;
  logic [MANT_W-1:0]    r_out_mant;
  logic [EXP_W-1:0]     r_out_exp;
  logic [SHIFT_W-1:0]   r_out_shift;
  logic                 r_out_zero;
  logic                 r_out_subn;

  logic                 w_mant_zero;
  logic                 w_term;
  logic [SHIFT_W-1:0]   w_step;

  assign w_mant_zero = (r_mant == '0);
  assign w_term      = w_mant_zero || r_mant[MANT_W-1] || (r_exp <= EXP_W'(1));

`ifdef NORM_SHIFT4_EN
  logic [2:0]           w_lz;
  logic [EXP_W-1:0]     w_exp_m1;
  logic [SHIFT_W-1:0]   w_room;

  norm_lz4 u_lz4 (
    .i_nib (r_mant[MANT_W-1 -: 4]),
    .o_lz  (w_lz)
  );

  // Clamp the step so it never overshoots exp==1 or the 23-bit shift ceiling;
  // this keeps results identical to the single-bit build.
  always_comb begin
    w_exp_m1 = r_exp - EXP_W'(1);
    w_room   = SHIFT_W'(MANT_W - 1) - r_shift;
    w_step   = SHIFT_W'(w_lz);
    if (w_exp_m1 < EXP_W'(w_step)) w_step = SHIFT_W'(w_exp_m1);
    if (w_room < w_step)           w_step = w_room;
  end
`else
  assign w_step = SHIFT_W'(1);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = ST_SCAN;
      end
      ST_SCAN: begin
        if (w_term) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mant      <= '0;
      r_exp       <= '0;
      r_shift     <= '0;
      r_out_mant  <= '0;
      r_out_exp   <= '0;
      r_out_shift <= '0;
      r_out_zero  <= 1'b0;
      r_out_subn  <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_mant  <= in_mant;
            r_exp   <= in_exp;
            r_shift <= '0;
          end
        end
        ST_SCAN: begin
          if (w_term) begin
            r_out_mant  <= r_mant;
            r_out_exp   <= r_mant[MANT_W-1] ? r_exp : '0;
            r_out_shift <= w_mant_zero ? '0 : r_shift;
            r_out_zero  <= w_mant_zero;
            r_out_subn  <= !w_mant_zero && !r_mant[MANT_W-1];
          end else begin
            r_mant  <= r_mant << w_step;
            r_exp   <= r_exp - EXP_W'(w_step);
            r_shift <= r_shift + w_step;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_mant  = r_out_mant;
  assign out_exp   = r_out_exp;
  assign out_shift = r_out_shift;
  assign out_zero  = r_out_zero;
  assign out_subn  = r_out_subn;

endmodule

// File: tb/tb_fp_norm_seq.sv
// Scoreboard bench for fp_norm_seq; expected latencies follow NORM_SHIFT4_EN when defined.
module tb_fp_norm_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_mant;
  logic [7:0]  in_exp;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_mant;
  logic [7:0]  out_exp;
  logic [4:0]  out_shift;
  logic        out_zero;
  logic        out_subn;

  typedef struct {
    logic [23:0] mant;
    logic [7:0]  exp;
    logic [4:0]  shift;
    logic        zero;
    logic        subn;
    int          lat;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

`ifdef NORM_SHIFT4_EN
  localparam bit S4 = 1'b1;
`else
  localparam bit S4 = 1'b0;
`endif

  fp_norm_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mant   (in_mant),
    .in_exp    (in_exp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mant  (out_mant),
    .out_exp   (out_exp),
    .out_shift (out_shift),
    .out_zero  (out_zero),
    .out_subn  (out_subn)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: latency on first out_valid, stability while stalled, data on handshake.
  logic        mon_seen = 1'b0;
  logic [23:0] s_mant;
  logic [7:0]  s_exp;
  logic [4:0]  s_shift;
  logic        s_zero, s_subn;

  always @(negedge clk) begin
    if (rst) begin
      mon_seen = 1'b0;
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        if (!mon_seen) begin
          chk("latency", 32'(cyc - exp_q[0].acc), 32'(exp_q[0].lat));
          mon_seen = 1'b1;
          s_mant = out_mant; s_exp = out_exp; s_shift = out_shift;
          s_zero = out_zero; s_subn = out_subn;
        end else begin
          chk("stall_mant",  32'(out_mant),  32'(s_mant));
          chk("stall_exp",   32'(out_exp),   32'(s_exp));
          chk("stall_shift", 32'(out_shift), 32'(s_shift));
          chk("stall_flags", 32'({out_zero, out_subn}), 32'({s_zero, s_subn}));
        end
        chk("in_ready_in_done", 32'(in_ready), 32'd0);
        if (out_ready) begin
          chk("out_mant",  32'(out_mant),  32'(exp_q[0].mant));
          chk("out_exp",   32'(out_exp),   32'(exp_q[0].exp));
          chk("out_shift", 32'(out_shift), 32'(exp_q[0].shift));
          chk("out_zero",  32'(out_zero),  32'(exp_q[0].zero));
          chk("out_subn",  32'(out_subn),  32'(exp_q[0].subn));
          void'(exp_q.pop_front());
          mon_seen = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [23:0] m, input logic [7:0] e, input exp_t x);
    int t = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_mant = m; in_exp = e;
    do begin @(negedge clk); t++; end while (!in_ready && t < 50);
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      x.acc = cyc;
      exp_q.push_back(x);
    end
    // Offer garbage while scanning: must be ignored.
    @(posedge clk); #1;
    in_mant = ~m; in_exp = ~e;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin @(negedge clk); t++; end
    if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic mk(input logic [23:0] om, input logic [7:0] oe, input logic [4:0] os,
                    input logic oz, input logic osb, input int l1, input int l4, output exp_t x);
    x.mant = om; x.exp = oe; x.shift = os; x.zero = oz; x.subn = osb;
    x.lat = S4 ? l4 : l1; x.acc = 0;
  endtask

  task automatic run(input logic [23:0] m, input logic [7:0] e,
                     input logic [23:0] om, input logic [7:0] oe, input logic [4:0] os,
                     input logic oz, input logic osb, input int l1, input int l4);
    exp_t x;
    mk(om, oe, os, oz, osb, l1, l4, x);
    send(m, e, x);
    wait_drain();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_mant"},  32'(out_mant),  32'd0);
    chk({tag, "_out_exp"},   32'(out_exp),   32'd0);
    chk({tag, "_out_shift"}, 32'(out_shift), 32'd0);
    chk({tag, "_out_flags"}, 32'({out_zero, out_subn}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t x;
    int   t;
    int   vcnt;
    rst = 1'b1; in_valid = 1'b0; in_mant = '0; in_exp = '0; out_ready = 1'b1;
    #1;
    chk_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run(24'h800000, 8'h80, 24'h800000, 8'h80,  5'd0,  1'b0, 1'b0, 2,  2);
    run(24'h000001, 8'h80, 24'h800000, 8'h69,  5'd23, 1'b0, 1'b0, 25, 8);
    run(24'h000100, 8'h05, 24'h001000, 8'h00,  5'd4,  1'b0, 1'b1, 6,  3);
    run(24'h000000, 8'h7F, 24'h000000, 8'h00,  5'd0,  1'b1, 1'b0, 2,  2);
    run(24'h400000, 8'h10, 24'h800000, 8'h0F,  5'd1,  1'b0, 1'b0, 3,  3);
    run(24'h0F0000, 8'h01, 24'h0F0000, 8'h00,  5'd0,  1'b0, 1'b1, 2,  2);
    run(24'h123456, 8'h40, 24'h91A2B0, 8'h3D,  5'd3,  1'b0, 1'b0, 5,  3);
    run(24'h800001, 8'h00, 24'h800001, 8'h00,  5'd0,  1'b0, 1'b0, 2,  2);
    run(24'h000003, 8'h03, 24'h00000C, 8'h00,  5'd2,  1'b0, 1'b1, 4,  3);

    // Back-pressure: hold out_ready low for 5 cycles in DONE.
    out_ready = 1'b0;
    mk(24'h800000, 8'h80, 5'd0, 1'b0, 1'b0, 2, 2, x);
    send(24'h800000, 8'h80, x);
    t = 0;
    while (!out_valid && t < 100) begin @(negedge clk); t++; end
    chk("stall_reached_done", 32'(out_valid), 32'd1);
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_hs", 32'(in_ready), 32'd1);
    wait_drain();

    // Reset in the middle of a long scan.
    mk(24'h800000, 8'h69, 5'd23, 1'b0, 1'b0, 25, 8, x);
    send(24'h000001, 8'h80, x);
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk_reset_outputs("midscan_rst");
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    vcnt = 0;
    repeat (30) begin @(negedge clk); if (out_valid) vcnt++; end
    chk("no_valid_after_rst", 32'(vcnt), 32'd0);
    run(24'h000001, 8'h80, 24'h800000, 8'h69, 5'd23, 1'b0, 1'b0, 25, 8);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_norm_seq.md
FP_NORM_SEQ -- requirements
Module: fp_norm_seq

Interface
REQ-001 SHALL have clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have in_valid, input, 1, operand offered.
REQ-004 SHALL have in_ready, output, 1, block idle and able to accept.
REQ-005 SHALL have in_mant, input, 24, unnormalized mantissa, hidden-bit position [23].
REQ-006 SHALL have in_exp, input, 8, biased exponent.
REQ-007 SHALL have out_valid, output, 1, result held.
REQ-008 SHALL have out_ready, input, 1, consumer accepts result.
REQ-009 SHALL have out_mant (24), out_exp (8), out_shift (5), out_zero (1) and out_subn (1) outputs: result mantissa, exponent, total left shift, zero flag, subnormal flag.

Function
REQ-010 SHALL implement states IDLE, SCAN, DONE.
REQ-011 SHALL assert in_ready only in IDLE; the accept cycle (in_valid & in_ready) loads mant, exp, shift=0 and moves to SCAN.
REQ-012 SHALL, in SCAN, treat mant==0, mant[23]==1 or exp<=1 as terminal and move to DONE with results registered.
REQ-013 SHALL, in non-terminal SCAN, shift mant left by 1 with zero fill, decrement exp by 1, increment shift by 1, and stay in SCAN.
REQ-014 SHALL produce out_exp = exp when mant[23]==1, else 0; out_subn = (mant!=0 & mant[23]==0).
REQ-015 SHALL produce, for mant==0, out_mant=0, out_exp=0, out_shift=0, out_zero=1, out_subn=0.
REQ-016 SHALL assert out_valid only in DONE, holding all out_* stable until out_valid & out_ready, then return to IDLE on the next edge.
REQ-017 SHALL give latency of 2 + N cycles from accept to out_valid, where N is the number of SCAN shift steps; out_shift never exceeds 23.
REQ-018 SHALL ignore in_valid outside IDLE; in_mant/in_exp are sampled only on the accept cycle.

Reset
REQ-019 SHALL, on rst assertion in any state and without waiting for clk, enter IDLE with in_ready=1 and all other outputs and internal registers 0.
REQ-020 SHALL discard any in-flight operand on reset; no out_valid pulse follows reset release.

Configuration
REQ-021 SHALL, with NORM_SHIFT4_EN defined, shift per SCAN step by min(lz4(mant[23:20]), exp-1, 23-shift), where lz4 is 0..4, adjusting exp and shift by the same amount.
REQ-022 SHALL, without NORM_SHIFT4_EN, shift exactly one bit per SCAN step (REQ-013); results are bit-identical in both builds and only latency differs.

Structure
REQ-023 SHALL place MANT_W=24, EXP_W=8, SHIFT_W=5 and the state enumeration in shared package fp_norm_pkg.
REQ-024 SHALL, under NORM_SHIFT4_EN, instantiate sub-module norm_lz4 (combinational 4-bit leading-zero counter, output 0..4).

Verification
REQ-025 SHALL cover: in_mant=0x800000, in_exp=0x80 -> out_valid 2 cycles after accept, out_mant=0x800000, out_exp=0x80, out_shift=0.
REQ-026 SHALL cover: in_mant=0x000001, in_exp=0x80 -> out_mant=0x800000, out_exp=0x69, out_shift=23; out_valid 25 cycles after accept (8 with NORM_SHIFT4_EN).
REQ-027 SHALL cover: in_mant=0x000100, in_exp=0x05 -> out_mant=0x001000, out_exp=0x00, out_shift=4, out_subn=1.
REQ-028 SHALL cover: in_mant=0x000000, in_exp=0x7F -> out_zero=1, out_exp=0, out_shift=0, out_valid 2 cycles after accept.
REQ-029 SHALL cover: out_ready held low 5 cycles in DONE -> out_* stable and in_ready=0 throughout; after the handshake, in_ready=1 on the next cycle.
REQ-030 SHALL cover: rst pulsed mid-SCAN of case REQ-026 -> outputs 0 and in_ready=1 immediately; no out_valid is produced; the next operand completes correctly.
